unified_buffer_arb: RTL

- Single-port on-chip scratch buffer shared by the host-side FIFO path and the compute unit.
- Generalises the earlier buffer in three ways: sub-word lane addressing for each channel width, valid/ready request channels with arbitration, and a one-cycle read response pipeline.
- Includes a built-in clear engine that zeroes the whole array.
- Sits between the I/O FIFOs and the systolic compute array.

---
 rtl/ub_pkg.sv | 20 ++
 rtl/ub_arbiter.sv | 58 +++++
 rtl/unified_buffer_arb.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/ub_pkg.sv
// ub_pkg: shared types and helpers for the unified scratch buffer.
//   ub_state_t   - clear engine state (idle / sweeping)
//   ub_grant_t   - which request channel owns the array this cycle
//   ub_lanes     - number of lanes of a given width in a buffer word
//   ub_lane_bits - width of a lane-index signal (at least 1 bit)
package ub_pkg;

    typedef enum logic {UB_IDLE, UB_CLEAR} ub_state_t;
    typedef enum logic {UB_GNT_COMP, UB_GNT_FIFO} ub_grant_t;

    function automatic int ub_lanes(input int word_w, input int lane_w);
        return word_w / lane_w;
    endfunction

    // A word holding a single lane still gets a 1-bit (always zero) index.
    function automatic int ub_lane_bits(input int word_w, input int lane_w);
        return (word_w / lane_w > 1) ? $clog2(word_w / lane_w) : 1;
    endfunction

endpackage

// File: rtl/ub_arbiter.sv
// ub_arbiter: two-requester arbiter for the unified buffer array port.
// Build option: UB_RR_ARB_EN selects round-robin between contending
// channels (compute favoured first after reset); without it compute has
// fixed priority and no pointer register exists.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   fifo_valid, comp_valid request valids
//   block                  clear running or starting; no grant may be accepted
//   grant                  channel selected this cycle
//   fifo_ready, comp_ready per-channel ready (valid && granted && !block)
module ub_arbiter
    import ub_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      fifo_valid,
    input  logic      comp_valid,
    input  logic      block,
    output ub_grant_t grant,
    output logic      fifo_ready,
    output logic      comp_ready
);

`ifdef UB_RR_ARB_EN
    // Channel that wins the next contended cycle; flips only on an
    // accepted contended grant so a blocked cycle does not skip a turn.
    ub_grant_t ptr;

    always_ff @(posedge clk) begin
        if (rst)
            ptr <= UB_GNT_COMP;
        else if (fifo_valid && comp_valid && !block)
            ptr <= (ptr == UB_GNT_COMP) ? UB_GNT_FIFO : UB_GNT_COMP;
    end

    always_comb begin
        grant = UB_GNT_COMP;
        if (fifo_valid && comp_valid)
            grant = ptr;
        else if (fifo_valid)
            grant = UB_GNT_FIFO;
    end
`else
    // Clock and reset only feed the round-robin pointer.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    always_comb begin
        grant = UB_GNT_COMP;
        if (fifo_valid && !comp_valid)
            grant = UB_GNT_FIFO;
    end
`endif

    assign comp_ready = comp_valid && (grant == UB_GNT_COMP) && !block;
    assign fifo_ready = fifo_valid && (grant == UB_GNT_FIFO) && !block;

endmodule

// File: rtl/unified_buffer_arb.sv
// unified_buffer_arb: single-port scratch buffer shared by the host FIFO
// path and the compute array, with lane-addressed accesses, valid/ready
// arbitration, 1-cycle read responses and a whole-array clear engine.
// Build option: UB_RR_ARB_EN (round-robin arbitration, see ub_arbiter).
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   fifo_req_* / fifo_rsp_*          FIFO channel, FIFO_DATA_WIDTH lanes
//   comp_req_* / comp_rsp_*          compute channel, COMPUTE_DATA_WIDTH lanes
//   clear_start                      pulse: zero every word
//   busy                             high while the clear sweep runs
module unified_buffer_arb
    import ub_pkg::*;
#(
    parameter int BUFFER_SIZE        = 1024,
    parameter int BUFFER_WORD_SIZE   = 16,
    parameter int FIFO_DATA_WIDTH    = 8,
    parameter int COMPUTE_DATA_WIDTH = 4,
    parameter int ADDRESS_SIZE       = $clog2(BUFFER_SIZE),
    parameter int FIFO_AW = ADDRESS_SIZE + $clog2(BUFFER_WORD_SIZE / FIFO_DATA_WIDTH),
    parameter int COMP_AW = ADDRESS_SIZE + $clog2(BUFFER_WORD_SIZE / COMPUTE_DATA_WIDTH)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          fifo_req_valid,
    output logic                          fifo_req_ready,
    input  logic                          fifo_req_we,
    input  logic [FIFO_AW-1:0]            fifo_req_addr,
    input  logic [FIFO_DATA_WIDTH-1:0]    fifo_req_wdata,
    output logic                          fifo_rsp_valid,
    output logic [FIFO_DATA_WIDTH-1:0]    fifo_rsp_data,
    input  logic                          comp_req_valid,
    output logic                          comp_req_ready,
    input  logic                          comp_req_we,
    input  logic [COMP_AW-1:0]            comp_req_addr,
    input  logic [COMPUTE_DATA_WIDTH-1:0] comp_req_wdata,
    output logic                          comp_rsp_valid,
    output logic [COMPUTE_DATA_WIDTH-1:0] comp_rsp_data,
    input  logic                          clear_start,
    output logic                          busy
);

    localparam int W       = BUFFER_WORD_SIZE;
    localparam int F_LANES = ub_lanes(W, FIFO_DATA_WIDTH);
    localparam int C_LANES = ub_lanes(W, COMPUTE_DATA_WIDTH);
    localparam int F_LB    = ub_lane_bits(W, FIFO_DATA_WIDTH);
    localparam int C_LB    = ub_lane_bits(W, COMPUTE_DATA_WIDTH);
    // Write granule is the compute lane; a FIFO lane spans GPF granules.
    localparam int GPF     = FIFO_DATA_WIDTH / COMPUTE_DATA_WIDTH;

    logic [W-1:0] mem [BUFFER_SIZE];

    ub_state_t               state, state_nxt;
    logic [ADDRESS_SIZE-1:0] clr_cnt;
    ub_grant_t               grant;

    // ---------------- address decode ----------------
    logic [ADDRESS_SIZE-1:0] f_word, c_word;
    logic [F_LB-1:0]         f_lane;
    logic [C_LB-1:0]         c_lane;
    logic [C_LANES-1:0]      f_mask, c_mask;

    assign f_word = fifo_req_addr[FIFO_AW-1 -: ADDRESS_SIZE];
    assign c_word = comp_req_addr[COMP_AW-1 -: ADDRESS_SIZE];

    if (F_LANES > 1) begin : g_flane
        assign f_lane = fifo_req_addr[F_LB-1:0];
    end else begin : g_flane_one
        assign f_lane = '0;
    end

    if (C_LANES > 1) begin : g_clane
        assign c_lane = comp_req_addr[C_LB-1:0];
    end else begin : g_clane_one
        assign c_lane = '0;
    end

    for (genvar g = 0; g < C_LANES; g++) begin : g_mask
        assign c_mask[g] = (c_lane == C_LB'(g));
        assign f_mask[g] = (f_lane == F_LB'(g / GPF));
    end

    // ---------------- arbitration ----------------
    assign busy = (state == UB_CLEAR);

    ub_arbiter u_arb (
        .clk        (clk),
        .rst        (rst),
        .fifo_valid (fifo_req_valid),
        .comp_valid (comp_req_valid),
        .block      (busy || clear_start),
        .grant      (grant),
        .fifo_ready (fifo_req_ready),
        .comp_ready (comp_req_ready)
    );

    logic fifo_acc, comp_acc;
    assign fifo_acc = fifo_req_valid && fifo_req_ready;
    assign comp_acc = comp_req_valid && comp_req_ready;

    // ---------------- array write port ----------------
    // Lane data is replicated across the word; the granule mask picks
    // which copies land, leaving the other lanes of the word untouched.
    logic [ADDRESS_SIZE-1:0] wr_word;
    logic [C_LANES-1:0]      gran_we;
    logic [W-1:0]            wr_data;

    always_comb begin
        wr_word = c_word;
        gran_we = '0;
        wr_data = {C_LANES{comp_req_wdata}};
        if (state == UB_CLEAR) begin
            wr_word = clr_cnt;
            gran_we = '1;
            wr_data = '0;
        end else if (grant == UB_GNT_FIFO) begin
            wr_word = f_word;
            wr_data = {F_LANES{fifo_req_wdata}};
            if (fifo_acc && fifo_req_we)
                gran_we = f_mask;
        end else if (comp_acc && comp_req_we) begin
            gran_we = c_mask;
        end
    end

    always_ff @(posedge clk) begin
        for (int g = 0; g < C_LANES; g++)
            if (gran_we[g])
                mem[wr_word][g*COMPUTE_DATA_WIDTH +: COMPUTE_DATA_WIDTH]
                    <= wr_data[g*COMPUTE_DATA_WIDTH +: COMPUTE_DATA_WIDTH];
    end

    // ---------------- read responses ----------------
    logic [W-1:0] f_rd_word, c_rd_word;
    assign f_rd_word = mem[f_word];
    assign c_rd_word = mem[c_word];

    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_rsp_valid <= 1'b0;
            comp_rsp_valid <= 1'b0;
            fifo_rsp_data  <= '0;
            comp_rsp_data  <= '0;
        end else begin
            fifo_rsp_valid <= fifo_acc && !fifo_req_we;
            comp_rsp_valid <= comp_acc && !comp_req_we;
            if (fifo_acc && !fifo_req_we)
                fifo_rsp_data <= f_rd_word[f_lane*FIFO_DATA_WIDTH +: FIFO_DATA_WIDTH];
            if (comp_acc && !comp_req_we)
                comp_rsp_data <= c_rd_word[c_lane*COMPUTE_DATA_WIDTH +: COMPUTE_DATA_WIDTH];
        end
    end

    // ---------------- clear engine ----------------
    always_ff @(posedge clk) begin
        if (rst)
            state <= UB_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst || state == UB_IDLE)
            clr_cnt <= '0;
        else
            clr_cnt <= clr_cnt + 1'b1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            UB_IDLE:  if (clear_start) state_nxt = UB_CLEAR;
            UB_CLEAR: if (clr_cnt == ADDRESS_SIZE'(BUFFER_SIZE - 1)) state_nxt = UB_IDLE;
            default:  state_nxt = UB_IDLE;
        endcase
    end

endmodule
